// File: rtl/sign_narrower.sv
// Narrows a signed 32-bit store value to byte/half/word, lane-replicated, with byte enables.
// Latency 1 cycle; 2-entry skid (main + skid) keeps full throughput, in_ready is registered.
module sign_narrower #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_addr,
  input  logic [1:0]        in_size,
  input  logic              in_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_be,
  output logic              out_ovf,
  output logic              out_misalign,
  output logic [CNT_W-1:0]  ovf_count,
  input  logic              ovf_clr
);

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [3:0]        be;
    logic              ovf;
    logic              mis;
  } res_t;

  res_t nxt, main_q, skid_q;
  logic main_vld, skid_vld, rdy_q;
  logic fit8, fit16;
  logic [7:0]  r8;
  logic [15:0] r16;

  // In range iff every bit above the sign position matches the sign bit
  assign fit8  = (&in_data[31:7])  | ~(|in_data[31:7]);
  assign fit16 = (&in_data[31:15]) | ~(|in_data[31:15]);

  always_comb begin
    nxt = '0;
    r8  = in_data[7:0];
    r16 = in_data[15:0];
    case (in_size)
      2'd0: begin
        nxt.ovf = ~fit8;
        if (nxt.ovf && in_sat) r8 = in_data[31] ? 8'h80 : 8'h7f;
        nxt.dat = {4{r8}};
        nxt.mis = 1'b0;
        nxt.be  = 4'b0001 << in_addr;
      end
      2'd1: begin
        nxt.ovf = ~fit16;
        if (nxt.ovf && in_sat) r16 = in_data[31] ? 16'h8000 : 16'h7fff;
        nxt.dat = {2{r16}};
        nxt.mis = in_addr[0];
        nxt.be  = nxt.mis ? 4'b0000 : (in_addr[1] ? 4'b1100 : 4'b0011);
      end
      default: begin
        nxt.ovf = 1'b0;
        nxt.dat = in_data;
        nxt.mis = |in_addr;
        nxt.be  = nxt.mis ? 4'b0000 : 4'b1111;
      end
    endcase
  end

  logic in_fire, out_fire, main_free;
  assign in_fire   = in_valid & rdy_q;
  assign out_fire  = main_vld & out_ready;
  assign main_free = ~main_vld | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (main_free) begin
        // Skid is older than anything arriving now; it always drains first
        if (skid_vld) begin
          main_q   <= skid_q;
          main_vld <= 1'b1;
          skid_vld <= 1'b0;
        end else if (in_fire) begin
          main_q   <= nxt;
          main_vld <= 1'b1;
        end else begin
          main_vld <= 1'b0;
        end
      end else if (in_fire) begin
        skid_q   <= nxt;
        skid_vld <= 1'b1;
        rdy_q    <= 1'b0;
      end else begin
        rdy_q <= ~skid_vld;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (out_fire && main_q.ovf && !(&ovf_count)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = main_vld;
  assign out_data     = main_q.dat;
  assign out_be       = main_q.be;
  assign out_ovf      = main_q.ovf;
  assign out_misalign = main_q.mis;

endmodule

// File: tb/tb_sign_narrower.sv
// Directed and randomized checks of sign_narrower against a range-based reference.
module tb_sign_narrower;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_addr = '0;
  logic [1:0]  in_size = '0;
  logic        in_sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_ovf;
  logic        out_misalign;
  logic [15:0] ovf_count;
  logic        ovf_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sign_narrower #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_addr(in_addr), .in_size(in_size), .in_sat(in_sat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_be(out_be), .out_ovf(out_ovf), .out_misalign(out_misalign),
    .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );

  // Reference: range test on the signed value, then lane placement
  function automatic logic [37:0] ref_nar(input logic [1:0] sz, input logic [1:0] ad,
                                          input logic [31:0] d, input logic sat);
    longint v, hi, lo, r;
    int n;
    logic ovf, mis;
    logic [31:0] rb, dat;
    logic [3:0] be;
    v  = longint'($signed(d));
    n  = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    hi = (64'sd1 <<< (n - 1)) - 1;
    lo = -hi - 1;
    ovf = (v > hi) || (v < lo);
    r = v;
    if (ovf && sat) r = (v < 0) ? lo : hi;
    rb = r[31:0];
    if (n == 8) begin
      dat = {4{rb[7:0]}}; mis = 1'b0; be = 4'b0001 << ad;
    end else if (n == 16) begin
      dat = {2{rb[15:0]}}; mis = ad[0]; be = mis ? 4'b0000 : (ad[1] ? 4'b1100 : 4'b0011);
    end else begin
      dat = rb; mis = (ad != 2'd0); be = mis ? 4'b0000 : 4'b1111;
    end
    return {dat, be, ovf, mis};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Single transfer into an empty pipe; result sits in the output register afterwards
  task automatic apply(input logic [1:0] sz, input logic [1:0] ad, input logic [31:0] d,
                       input logic sat);
    in_size = sz; in_addr = ad; in_data = d; in_sat = sat;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, out_data, out_be, out_ovf, out_misalign, ovf_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h be=%b o=%b m=%b c=%0d, want all zero",
               out_valid, out_data, out_be, out_ovf, out_misalign, ovf_count);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_byte();
    apply(2'd0, 2'd2, 32'hFFFF_FF85, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h8585_8585 || out_be !== 4'b0100 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL byte_fit: got v=%b d=%h be=%b o=%b want v=1 d=85858585 be=0100 o=0",
               out_valid, out_data, out_be, out_ovf);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL byte_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_half();
    apply(2'd1, 2'd0, 32'h0001_2345, 1'b1);
    checks++;
    if (out_data !== 32'h7FFF_7FFF || out_be !== 4'b0011 || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL half_sat: got d=%h be=%b o=%b want d=7fff7fff be=0011 o=1", out_data, out_be, out_ovf);
    end
    apply(2'd1, 2'd0, 32'h0001_2345, 1'b0);
    checks++;
    if (out_data !== 32'h2345_2345 || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL half_wrap: got d=%h o=%b want d=23452345 o=1", out_data, out_ovf);
    end
    tick();
  endtask

  task automatic test_min_misalign();
    apply(2'd0, 2'd0, 32'h8000_0000, 1'b1);
    checks++;
    if (out_data !== 32'h8080_8080 || out_ovf !== 1'b1 || out_be !== 4'b0001) begin
      failures++;
      $display("FAIL byte_min: got d=%h o=%b be=%b want d=80808080 o=1 be=0001", out_data, out_ovf, out_be);
    end
    apply(2'd1, 2'd1, 32'h0000_0012, 1'b0);
    checks++;
    if (out_be !== 4'b0000 || out_misalign !== 1'b1 || out_data !== 32'h0012_0012) begin
      failures++;
      $display("FAIL half_misalign: got be=%b m=%b d=%h want be=0000 m=1 d=00120012",
               out_be, out_misalign, out_data);
    end
    apply(2'd2, 2'd0, 32'h8000_0001, 1'b1);
    checks++;
    if (out_data !== 32'h8000_0001 || out_be !== 4'b1111 || out_ovf !== 1'b0 || out_misalign !== 1'b0) begin
      failures++;
      $display("FAIL word: got d=%h be=%b o=%b m=%b want d=80000001 be=1111 o=0 m=0",
               out_data, out_be, out_ovf, out_misalign);
    end
    tick();
  endtask

  task automatic test_ovf_count();
    checks++;
    if (ovf_count !== 16'd3) begin
      failures++; $display("FAIL ovf_count_directed: got %0d want 3", ovf_count);
    end
    apply(2'd1, 2'd0, 32'h0001_2345, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf_count !== 16'd0) begin
      failures++; $display("FAIL ovf_clr_wins: got %0d want 0", ovf_count);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d [6];
    int acc;
    for (int i = 0; i < 6; i++) d[i] = 32'h1000_0000 + i;
    acc = 0;
    in_size = 2'd2; in_addr = 2'd0; in_sat = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = d[0];
    for (int c = 0; c < 3; c++) begin
      if (in_ready) acc++;
      tick();
      in_data = d[acc];
    end
    checks++;
    if (acc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== d[0]) begin
      failures++;
      $display("FAIL stall_fill: acc=%0d in_ready=%b v=%b d=%h want acc=2 in_ready=0 v=1 d=%h",
               acc, in_ready, out_valid, out_data, d[0]);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== d[1] || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_drain: v=%b d=%h in_ready=%b want v=1 d=%h in_ready=1",
               out_valid, out_data, in_ready, d[1]);
    end
    in_valid = 1'b1;
    for (int i = 2; i < 6; i++) begin
      in_data = d[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d[i] || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d: v=%b d=%h rdy=%b want v=1 d=%h rdy=1",
                 i, out_valid, out_data, in_ready, d[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [37:0] q[$];
    logic [37:0] exp, got, held;
    logic [31:0] r;
    logic held_vld;
    int sent, rcvd, cyc, model_cnt, errs;
    sent = 0; rcvd = 0; cyc = 0; model_cnt = 0; errs = 0; held_vld = 1'b0; held = '0;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    while (rcvd < 1000 && cyc < 20000) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: in_data = $urandom;
        1: in_data = {{25{r[7]}}, r[6:0]};
        2: in_data = {{17{r[15]}}, r[14:0]};
        default: in_data = {{24{r[8]}}, r[7:0]};
      endcase
      in_size = 2'($urandom_range(0, 3));
      in_addr = 2'($urandom_range(0, 3));
      in_sat  = 1'($urandom_range(0, 1));
      in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      got = {out_data, out_be, out_ovf, out_misalign};
      if (held_vld && out_valid && got !== held) errs++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) errs++;
        else begin
          exp = q.pop_front();
          if (got !== exp) begin
            errs++;
            if (errs < 5) $display("FAIL random_txn_%0d: got %h want %h", rcvd, got, exp);
          end
          if (exp[1]) model_cnt++;
        end
        rcvd++;
      end
      held_vld = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) begin
        q.push_back(ref_nar(in_size, in_addr, in_data, in_sat));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (errs != 0 || rcvd != 1000) begin
      failures++;
      $display("FAIL random_stream: errors=%0d received=%0d want errors=0 received=1000", errs, rcvd);
    end
    checks++;
    if (ovf_count !== 16'(model_cnt)) begin
      failures++; $display("FAIL random_ovf_count: got %0d want %0d", ovf_count, model_cnt);
    end
    out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    in_size = 2'd2; in_addr = 2'd0; in_sat = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hAAAA_0001; tick();
    in_data = 32'hAAAA_0002; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: v=%b d=%h rdy=%b want v=0 d=0 rdy=0", out_valid, out_data, in_ready);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL reset_mid_stale_%0d: out_valid got %b want 0", i, out_valid);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid_ready: got %b want 1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_min_misalign();
    test_ovf_count();
    test_stall();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
